ratio_clk_gen: RTL and testbench

- Multi-channel, glitch-free programmable clock-enable/divided-clock generator; successor to the power-of-two ratio clock.
- Per channel: arbitrary integer period, programmable high time (duty), handshaked reconfiguration applied only at period boundaries, graceful stop, and a global phase-align sync.
- Sits in the clocking/timing subsystem and feeds peripheral strobes and derived clocks from one fabric clock.

---
 rtl/ratio_clk_gen.sv | 143 ++++++++++++++
 tb/tb_ratio_clk_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ratio_clk_gen.sv
// ============================================================================
// Module  : ratio_clk_gen
// Purpose : Multi-channel glitch-free programmable divided-clock / tick source.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ratio_clk_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic                    sync_i,
  input  logic [NUM_CH-1:0]       cfg_valid_i,
  output logic [NUM_CH-1:0]       cfg_ready_o,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div_i,
  input  logic [NUM_CH*DIV_W-1:0] cfg_high_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] c_one = {{(DIV_W-1){1'b0}}, 1'b1};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] high_act_q, high_act_d;
    logic [DIV_W-1:0] div_sh_q, div_sh_d;
    logic [DIV_W-1:0] high_sh_q, high_sh_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;

    logic w_active;
    logic w_last;
    logic w_sync;
    logic w_apply;
    logic w_take;

    assign w_active = (state_q != ST_IDLE);
    assign w_last   = w_active && (cnt_q == div_act_q);
    assign w_sync   = sync_i && w_active;
    // Active settings only change where a new period begins (or when idle).
    assign w_apply  = pend_q && (!w_active || w_last || w_sync);
    assign w_take   = cfg_valid_i[g] && !pend_q;

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      high_act_d = high_act_q;
      div_sh_d   = div_sh_q;
      high_sh_d  = high_sh_q;
      pend_d     = pend_q;

      if (w_apply) begin
        div_act_d  = div_sh_q;
        high_act_d = high_sh_q;
        pend_d     = 1'b0;
      end
      if (w_take) begin
        div_sh_d  = cfg_div_i[g*DIV_W +: DIV_W];
        high_sh_d = cfg_high_i[g*DIV_W +: DIV_W];
        pend_d    = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (en_i[g]) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN, ST_DRAIN: begin
          // A sync restart outranks both the wrap and the drain exit.
          if (w_sync) begin
            cnt_d   = '0;
            state_d = en_i[g] ? ST_RUN : ST_DRAIN;
          end else if (w_last) begin
            cnt_d   = '0;
            state_d = en_i[g] ? ST_RUN : ST_IDLE;
          end else begin
            cnt_d   = cnt_q + c_one;
            state_d = en_i[g] ? ST_RUN : ST_DRAIN;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase

      busy_d = (state_d != ST_IDLE);
      clk_d  = busy_d && (cnt_d < high_act_d);
      tick_d = busy_d && (cnt_d == div_act_d) && !w_sync;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        div_act_q  <= '0;
        high_act_q <= '0;
        div_sh_q   <= '0;
        high_sh_q  <= '0;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        high_act_q <= high_act_d;
        div_sh_q   <= div_sh_d;
        high_sh_q  <= high_sh_d;
        pend_q     <= pend_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
        busy_q     <= busy_d;
      end
    end

    assign clk_o[g]       = clk_q;
    assign tick_o[g]      = tick_q;
    assign busy_o[g]      = busy_q;
    assign cfg_ready_o[g] = ~pend_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ratio_clk_gen.sv
// ============================================================================
// Module  : tb_ratio_clk_gen
// Purpose : Directed bench for ratio_clk_gen with a cycle-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ratio_clk_gen;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic              clk_i;
  logic              rst_i;
  logic [NCH-1:0]    en_i;
  logic              sync_i;
  logic [NCH-1:0]    cfg_valid_i;
  logic [NCH-1:0]    cfg_ready_o;
  logic [NCH*DW-1:0] cfg_div_i;
  logic [NCH*DW-1:0] cfg_high_i;
  logic [NCH-1:0]    clk_o;
  logic [NCH-1:0]    tick_o;
  logic [NCH-1:0]    busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  ratio_clk_gen #(.NUM_CH(NCH), .DIV_W(DW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .sync_i     (sync_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_div_i  (cfg_div_i),
    .cfg_high_i (cfg_high_i),
    .clk_o      (clk_o),
    .tick_o     (tick_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: a channel is either busy or not; a busy channel counts a
  // phase through its period and stops at any period end where en is low.
  int           m_ph   [NCH];
  int           m_div  [NCH];
  int           m_hi   [NCH];
  int           m_sdiv [NCH];
  int           m_shi  [NCH];
  bit           m_busy [NCH];
  bit           m_pend [NCH];
  logic [NCH-1:0] m_clk, m_tick, m_bsy, m_rdy;
  bit           m_valid = 1'b0;
  bit           mb_last, mb_sy, mb_app, mb_take;

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCH; k++) begin
        m_ph[k] = 0; m_div[k] = 0; m_hi[k] = 0; m_sdiv[k] = 0; m_shi[k] = 0;
        m_busy[k] = 1'b0; m_pend[k] = 1'b0;
      end
      m_clk = '0; m_tick = '0; m_bsy = '0; m_rdy = '1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int k = 0; k < NCH; k++) begin
        mb_last = m_busy[k] && (m_ph[k] == m_div[k]);
        mb_sy   = sync_i && m_busy[k];
        mb_app  = m_pend[k] && (!m_busy[k] || mb_last || mb_sy);
        mb_take = cfg_valid_i[k] && !m_pend[k];
        if (mb_app) begin
          m_div[k] = m_sdiv[k]; m_hi[k] = m_shi[k]; m_pend[k] = 1'b0;
        end
        if (mb_take) begin
          m_sdiv[k] = int'(cfg_div_i[k*DW +: DW]);
          m_shi[k]  = int'(cfg_high_i[k*DW +: DW]);
          m_pend[k] = 1'b1;
        end
        if (!m_busy[k]) begin
          if (en_i[k]) begin
            m_busy[k] = 1'b1; m_ph[k] = 0;
          end
        end else if (mb_sy) begin
          m_ph[k] = 0;
        end else if (mb_last) begin
          m_ph[k] = 0;
          if (!en_i[k]) m_busy[k] = 1'b0;
        end else begin
          m_ph[k] = m_ph[k] + 1;
        end
        m_clk[k]  = m_busy[k] && (m_ph[k] < m_hi[k]);
        m_tick[k] = m_busy[k] && (m_ph[k] == m_div[k]) && !mb_sy;
        m_bsy[k]  = m_busy[k];
        m_rdy[k]  = !m_pend[k];
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_valid) begin
      chk("model_clk_o", 32'(clk_o), 32'(m_clk));
      chk("model_tick_o", 32'(tick_o), 32'(m_tick));
      chk("model_busy_o", 32'(busy_o), 32'(m_bsy));
      chk("model_cfg_ready_o", 32'(cfg_ready_o), 32'(m_rdy));
    end
  end

  task automatic cfg(input int ch, input int d, input int h);
    cfg_div_i[ch*DW +: DW]  = d[DW-1:0];
    cfg_high_i[ch*DW +: DW] = h[DW-1:0];
    cfg_valid_i[ch]         = 1'b1;
  endtask

  logic [15:0] pa, pb, pc;

  initial begin
    rst_i = 1'b1; en_i = '0; sync_i = 1'b0; cfg_valid_i = '0;
    cfg_div_i = '0; cfg_high_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_clk_o", 32'(clk_o), 32'h0);
    chk("rst_tick_o", 32'(tick_o), 32'h0);
    chk("rst_busy_o", 32'(busy_o), 32'h0);
    chk("rst_ready_o", 32'(cfg_ready_o), 32'hF);
    rst_i = 1'b0;

    // ch0: div=4 high=2 from idle
    cfg(0, 4, 2);
    @(negedge clk_i); cfg_valid_i = '0;
    chk("ch0_ready_pending", 32'(cfg_ready_o[0]), 32'h0);
    @(negedge clk_i);
    chk("ch0_ready_applied", 32'(cfg_ready_o[0]), 32'h1);
    en_i[0] = 1'b1;
    pa = '0; pb = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      pa = {pa[14:0], clk_o[0]}; pb = {pb[14:0], tick_o[0]};
    end
    chk("ch0_clk_pattern", 32'(pa[9:0]), 32'b1100011000);
    chk("ch0_tick_pattern", 32'(pb[9:0]), 32'b0000100001);

    // mid-period reconfig to div=2 high=1 at cnt=1
    repeat (2) @(negedge clk_i);
    cfg(0, 2, 1);
    @(negedge clk_i); cfg_valid_i = '0;
    chk("ch0_ready_low_midperiod", 32'(cfg_ready_o[0]), 32'h0);
    repeat (2) @(negedge clk_i);
    chk("ch0_ready_low_lastcycle", 32'(cfg_ready_o[0]), 32'h0);
    chk("ch0_tick_old_period_end", 32'(tick_o[0]), 32'h1);
    pa = '0; pb = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      pa = {pa[14:0], clk_o[0]}; pb = {pb[14:0], tick_o[0]};
    end
    chk("ch0_new_clk_pattern", 32'(pa[5:0]), 32'b100100);
    chk("ch0_new_tick_pattern", 32'(pb[5:0]), 32'b001001);
    chk("ch0_ready_back", 32'(cfg_ready_o[0]), 32'h1);

    // ch3 edge configs
    cfg(3, 0, 1);
    @(negedge clk_i); cfg_valid_i = '0;
    @(negedge clk_i);
    en_i[3] = 1'b1;
    pa = '0; pb = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      pa = {pa[14:0], clk_o[3]}; pb = {pb[14:0], tick_o[3]};
    end
    chk("ch3_div0_clk", 32'(pa[3:0]), 32'b1111);
    chk("ch3_div0_tick", 32'(pb[3:0]), 32'b1111);
    cfg(3, 0, 0);
    @(negedge clk_i); cfg_valid_i = '0;
    pa = '0; pb = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      pa = {pa[14:0], clk_o[3]}; pb = {pb[14:0], tick_o[3]};
    end
    chk("ch3_high0_clk", 32'(pa[3:0]), 32'b0000);
    chk("ch3_high0_tick", 32'(pb[3:0]), 32'b1111);
    cfg(3, 3, 7);
    @(negedge clk_i); cfg_valid_i = '0;
    @(negedge clk_i);
    pa = '0; pb = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      pa = {pa[14:0], clk_o[3]}; pb = {pb[14:0], tick_o[3]};
    end
    chk("ch3_highbig_clk", 32'(pa[7:0]), 32'hFF);
    chk("ch3_highbig_tick", 32'(pb[7:0]), 32'b00100010);
    en_i[3] = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("ch3_stopped_busy", 32'(busy_o[3]), 32'h0);

    // ch1 drain: div=5 high=3, drop en at cnt=2
    cfg(1, 5, 3);
    @(negedge clk_i); cfg_valid_i = '0;
    @(negedge clk_i);
    en_i[1] = 1'b1;
    repeat (3) @(negedge clk_i);
    en_i[1] = 1'b0;
    pa = '0; pb = '0; pc = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      pa = {pa[14:0], busy_o[1]}; pb = {pb[14:0], tick_o[1]}; pc = {pc[14:0], clk_o[1]};
    end
    chk("ch1_drain_busy", 32'(pa[3:0]), 32'b1110);
    chk("ch1_drain_tick", 32'(pb[3:0]), 32'b0010);
    chk("ch1_drain_clk", 32'(pc[3:0]), 32'b0000);
    en_i[1] = 1'b1;
    repeat (3) @(negedge clk_i);
    en_i[1] = 1'b0;
    @(negedge clk_i);
    en_i[1] = 1'b1;
    pa = '0; pb = '0; pc = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      pa = {pa[14:0], busy_o[1]}; pb = {pb[14:0], tick_o[1]}; pc = {pc[14:0], clk_o[1]};
    end
    chk("ch1_rearm_busy", 32'(pa[5:0]), 32'b111111);
    chk("ch1_rearm_tick", 32'(pb[5:0]), 32'b010000);
    chk("ch1_rearm_clk", 32'(pc[5:0]), 32'b001110);

    // sync: ch0 div=4, ch2 div=6, ch3 idle
    cfg(0, 4, 2);
    cfg(2, 6, 3);
    @(negedge clk_i); cfg_valid_i = '0;
    repeat (4) @(negedge clk_i);
    en_i[2] = 1'b1;
    repeat (3) @(negedge clk_i);
    sync_i = 1'b1;
    @(negedge clk_i);
    sync_i = 1'b0;
    chk("sync_tick_suppressed", 32'(tick_o & 4'b0101), 32'h0);
    chk("sync_ch3_idle", 32'({busy_o[3], clk_o[3]}), 32'h0);
    pa = '0; pb = '0;
    for (int i = 0; i < 7; i++) begin
      if (i != 0) @(negedge clk_i);
      if (i < 5) pa = {pa[14:0], clk_o[0]};
      pb = {pb[14:0], clk_o[2]};
    end
    chk("sync_ch0_clk", 32'(pa[4:0]), 32'b11000);
    chk("sync_ch2_clk", 32'(pb[6:0]), 32'b1110000);

    // reset with a pending config on ch2
    cfg(2, 2, 1);
    @(negedge clk_i); cfg_valid_i = '0;
    chk("ch2_pending_ready", 32'(cfg_ready_o[2]), 32'h0);
    rst_i = 1'b1; en_i = '0;
    @(negedge clk_i);
    chk("rst2_clk_o", 32'(clk_o), 32'h0);
    chk("rst2_tick_o", 32'(tick_o), 32'h0);
    chk("rst2_busy_o", 32'(busy_o), 32'h0);
    chk("rst2_ready_o", 32'(cfg_ready_o), 32'hF);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("post_rst_idle_busy", 32'(busy_o), 32'h0);
    chk("post_rst_idle_clk", 32'(clk_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
